// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the serial two's-complement add/sub unit
package addsub_pkg;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_SUB = 2'b01,
      MODE_NEG = 2'b10,
      MODE_ABS = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic logic [63:0] smax_const(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] smin_const(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/twos_addsub_serial_digit_adder.sv
// rtl/twos_addsub_serial_digit_adder.sv - D-bit ripple-carry slice reused for every digit
module digit_adder #(
   parameter int D = 1
) (
   input  logic [D-1:0] x,
   input  logic [D-1:0] y,
   input  logic         cin,
   output logic [D-1:0] s,
   output logic         cout
);

   logic w_c;

   always_comb begin
      s   = '0;
      w_c = cin;
      for (int i = 0; i < D; i++) begin
         s[i] = x[i] ^ y[i] ^ w_c;
         w_c  = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
      end
      cout = w_c;
   end

endmodule

// File: rtl/twos_addsub_serial.sv
// rtl/twos_addsub_serial.sv - digit-serial ADD/SUB/NEG/ABS unit, LSB digit first
// Optional saturation on overflow when ADDSUB_SAT_EN is defined.
module twos_addsub_serial
   import addsub_pkg::*;
#(
   parameter int W = 4,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         carry,
   output logic         overflow,
   output logic         zero
);

   localparam int NDIG = W / D;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [W-1:0] MAXV = W'(smax_const(W));
   localparam logic [W-1:0] MINV = W'(smin_const(W));

   if (W < 2 || D < 1 || (W % D) != 0) begin : g_param_err
      $error("twos_addsub_serial: need W >= 2 and W a multiple of D");
   end

   state_t          r_state;
   mode_t           r_mode;
   logic [W-1:0]    r_x, r_y, r_res;
   logic            r_c, r_sa, r_sb, r_amin;
   logic [CW-1:0]   r_cnt;

   logic [D-1:0]    w_s;
   logic            w_cout;
   logic [W+D-1:0]  w_cat;
   logic [W-1:0]    w_res_next, w_final;
   logic            w_ov;
   logic [W-1:0]    w_ld_x, w_ld_y;
   logic            w_ld_c;

   digit_adder #(.D(D)) u_digit (
      .x    (r_x[D-1:0]),
      .y    (r_y[D-1:0]),
      .cin  (r_c),
      .s    (w_s),
      .cout (w_cout)
   );

   // Sum digits enter from the MSB side so the last digit lands in the top slot.
   assign w_cat      = {w_s, r_res};
   assign w_res_next = w_cat[W+D-1:D];

   always_comb begin
      w_ld_x = a;
      w_ld_y = b;
      w_ld_c = 1'b0;
      case (mode_t'(mode))
         MODE_SUB: begin w_ld_y = ~b; w_ld_c = 1'b1; end
         MODE_NEG: begin w_ld_x = '0; w_ld_y = ~a; w_ld_c = 1'b1; end
         MODE_ABS: begin
            if (a[W-1]) begin
               w_ld_x = '0; w_ld_y = ~a; w_ld_c = 1'b1;
            end else begin
               w_ld_y = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      case (r_mode)
         MODE_ADD: w_ov = (r_sa == r_sb) && (w_res_next[W-1] != r_sa);
         MODE_SUB: w_ov = (r_sa != r_sb) && (w_res_next[W-1] != r_sa);
         default:  w_ov = r_amin;
      endcase
`ifdef ADDSUB_SAT_EN
      // Overflowed ADD/SUB share A's sign with the true result; NEG/ABS of min is positive.
      if (w_ov) begin
         if ((r_mode == MODE_ADD) || (r_mode == MODE_SUB))
            w_final = r_sa ? MINV : MAXV;
         else
            w_final = MAXV;
      end else begin
         w_final = w_res_next;
      end
`else
      w_final = w_res_next;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_mode    <= MODE_ADD;
         r_x       <= '0;
         r_y       <= '0;
         r_res     <= '0;
         r_c       <= 1'b0;
         r_sa      <= 1'b0;
         r_sb      <= 1'b0;
         r_amin    <= 1'b0;
         r_cnt     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mode   <= mode_t'(mode);
                  r_x      <= w_ld_x;
                  r_y      <= w_ld_y;
                  r_c      <= w_ld_c;
                  r_sa     <= a[W-1];
                  r_sb     <= b[W-1];
                  r_amin   <= (a == MINV);
                  r_cnt    <= '0;
                  in_ready <= 1'b0;
                  r_state  <= BUSY;
               end
            end
            BUSY: begin
               r_x   <= r_x >> D;
               r_y   <= r_y >> D;
               r_c   <= w_cout;
               r_res <= w_res_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(NDIG - 1)) begin
                  result    <= w_final;
                  carry     <= w_cout;
                  overflow  <= w_ov;
                  zero      <= (w_final == '0);
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_twos_addsub_serial.sv
// tb/tb_twos_addsub_serial.sv - randomized and directed checks of twos_addsub_serial at W=4/D=1 and W=8/D=4
module tb_twos_addsub_serial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0, result4;
   logic [1:0] mode4 = '0;
   logic       carry4, overflow4, zero4;

   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, result8;
   logic [1:0] mode8 = '0;
   logic       carry8, overflow8, zero8;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   twos_addsub_serial #(.W(4), .D(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .carry(carry4), .overflow(overflow4), .zero(zero4)
   );

   twos_addsub_serial #(.W(8), .D(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .carry(carry8), .overflow(overflow8), .zero(zero8)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: signed arithmetic on integers, then reduce/saturate to w bits.
   function automatic void model(input int w, input logic [1:0] m, input longint av, input longint bv,
                                 output longint r, output bit c, output bit ov);
      longint md, mx, mn, sa, sb, t;
      md = longint'(1) << w;
      mx = (md / 2) - 1;
      mn = -(md / 2);
      sa = (av >= md / 2) ? av - md : av;
      sb = (bv >= md / 2) ? bv - md : bv;
      case (m)
         2'b00: begin t = sa + sb; c = (av + bv) >= md; end
         2'b01: begin t = sa - sb; c = (av >= bv); end
         2'b10: begin t = -sa; c = (av == 0); end
         default: begin t = (sa < 0) ? -sa : sa; c = 1'b0; end
      endcase
      ov = (t > mx) || (t < mn);
      r = t & (md - 1);
`ifdef ADDSUB_SAT_EN
      if (ov) r = ((t > 0) ? mx : mn) & (md - 1);
`endif
   endfunction

   task automatic op4(input logic [1:0] m, input logic [3:0] av, input logic [3:0] bv);
      longint er; bit ec, eo; int lat; string id;
      model(4, m, longint'(av), longint'(bv), er, ec, eo);
      id = $sformatf("w4 m%0d a%0h b%0h", m, av, bv);
      @(negedge clk);
      chk({id, " in_ready"}, in_ready4, 1);
      in_valid4 = 1'b1; mode4 = m; a4 = av; b4 = bv;
      @(posedge clk); #1 in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
      chk({id, " latency"}, lat, 4);
      chk({id, " result"}, result4, er);
      chk({id, " carry"}, carry4, ec);
      chk({id, " overflow"}, overflow4, eo);
      chk({id, " zero"}, zero4, (er == 0));
      @(negedge clk) out_ready4 = 1'b1;
      @(posedge clk); #1 out_ready4 = 1'b0;
      chk({id, " out_valid drop"}, out_valid4, 0);
      chk({id, " in_ready back"}, in_ready4, 1);
   endtask

   task automatic op8(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv, input int hold);
      longint er; bit ec, eo; int lat; string id;
      model(8, m, longint'(av), longint'(bv), er, ec, eo);
      id = $sformatf("w8 m%0d a%0h b%0h", m, av, bv);
      @(negedge clk);
      chk({id, " in_ready"}, in_ready8, 1);
      in_valid8 = 1'b1; mode8 = m; a8 = av; b8 = bv;
      @(posedge clk); #1 in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 40) begin @(posedge clk); #1; lat++; end
      chk({id, " latency"}, lat, 2);
      chk({id, " result"}, result8, er);
      chk({id, " carry"}, carry8, ec);
      chk({id, " overflow"}, overflow8, eo);
      chk({id, " zero"}, zero8, (er == 0));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({id, " hold out_valid"}, out_valid8, 1);
         chk({id, " hold result"}, result8, er);
         chk({id, " hold in_ready"}, in_ready8, 0);
      end
      @(negedge clk) out_ready8 = 1'b1;
      @(posedge clk); #1 out_ready8 = 1'b0;
      chk({id, " out_valid drop"}, out_valid8, 0);
      chk({id, " in_ready back"}, in_ready8, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", out_valid4, 0);
      chk("reset in_ready", in_ready4, 1);
      chk("reset result", result4, 0);
      chk("reset zero", zero4, 0);
      @(negedge clk) rst_n = 1'b1;

      op4(2'b00, 4'b0111, 4'b0001);
      op4(2'b01, 4'b0011, 4'b0101);
      op4(2'b01, 4'b0101, 4'b0101);
      for (int i = 0; i < 16; i++) op4(2'b10, 4'(i), 4'(i + 3));
      op4(2'b11, 4'b1011, 4'b0000);
      op4(2'b11, 4'b0110, 4'b1111);
      op4(2'b11, 4'b1000, 4'b0000);

      op8(2'b00, 8'h7F, 8'h01, 5);
      op8(2'b01, 8'h80, 8'h01, 0);
      op8(2'b11, 8'h80, 8'h00, 0);

      // Reset arrives while dut4 is mid-operation.
      @(negedge clk);
      in_valid4 = 1'b1; mode4 = 2'b00; a4 = 4'b0010; b4 = 4'b0011;
      @(posedge clk); #1 in_valid4 = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      chk("midrst out_valid", out_valid4, 0);
      chk("midrst in_ready", in_ready4, 1);
      chk("midrst result", result4, 0);
      chk("midrst carry", carry4, 0);
      chk("midrst overflow", overflow4, 0);
      chk("midrst zero", zero4, 0);
      repeat (6) @(posedge clk);
      #1 chk("midrst no late out_valid", out_valid4, 0);
      op4(2'b00, 4'b0010, 4'b0011);

      for (int i = 0; i < 40; i++) op4(2'($urandom), 4'($urandom), 4'($urandom));
      for (int i = 0; i < 30; i++) op8(2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
